// File: rtl/tempsense_pkg.sv
// Shared types and defaults for the temperature-sensor ring-oscillator frequency counter.
package tempsense_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWarm,
        StMeasure,
        StHold
    } state_e;

    localparam int unsigned DEF_CNT_W        = 16;
    localparam int unsigned DEF_WIN_W        = 16;
    localparam int unsigned DEF_SETTLE       = 4;
    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned SETTLE_CNT_W     = 4;

endpackage

// File: rtl/ro_sync_edge.sv
// Synchronises the free-running ring-oscillator output into the CLK domain and flags its
// rising edges with a one-cycle pulse.
module ro_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: warm-up, windowed saturating edge count, start/done handshake.
// Define RO_FREQ_COUNTER_CONT_EN for back-to-back windows while START stays high.
module ro_freq_counter
    import tempsense_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned WIN_W       = DEF_WIN_W,
    parameter int unsigned SETTLE      = DEF_SETTLE,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             RO_IN,
    input  logic             START,
    input  logic [WIN_W-1:0] WIN,
    output logic             EN_RO,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    localparam logic [SETTLE_CNT_W-1:0] SettleLast = SETTLE_CNT_W'(SETTLE - 1);

    state_e                  r_state;
    logic                    r_en_ro;
    logic                    r_busy;
    logic                    r_done;
    logic [CNT_W-1:0]        r_count;
    logic                    r_ovf;
    logic [WIN_W-1:0]        r_win;
    logic [WIN_W-1:0]        r_win_cnt;
    logic [SETTLE_CNT_W-1:0] r_settle;

    logic                    w_rise;
    logic                    w_win_last;
    logic                    w_sat;
    logic [CNT_W-1:0]        w_acc;
    logic                    w_acc_ovf;
    logic [CNT_W-1:0]        w_acc_next;
    logic                    w_acc_ovf_next;

    ro_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk   (CLK),
        .i_rst_n (RN),
        .i_async (RO_IN),
        .o_rise  (w_rise)
    );

`ifdef RO_FREQ_COUNTER_CONT_EN
    // Running count kept apart so COUNT only changes at window boundaries.
    logic [CNT_W-1:0] r_acc;
    logic             r_acc_ovf;
    assign w_acc     = r_acc;
    assign w_acc_ovf = r_acc_ovf;
`else
    assign w_acc     = r_count;
    assign w_acc_ovf = r_ovf;
`endif

    assign w_sat          = &w_acc;
    assign w_acc_next     = (w_rise && !w_sat) ? w_acc + 1'b1 : w_acc;
    assign w_acc_ovf_next = w_acc_ovf | (w_rise & w_sat);
    assign w_win_last     = (r_win_cnt == r_win - 1'b1);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state   <= StIdle;
            r_en_ro   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_win     <= '0;
            r_win_cnt <= '0;
            r_settle  <= '0;
`ifdef RO_FREQ_COUNTER_CONT_EN
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle, StHold: begin
                    if (START) begin
                        r_state  <= StWarm;
                        r_win    <= WIN;
                        r_count  <= '0;
                        r_ovf    <= 1'b0;
                        r_done   <= 1'b0;
                        r_en_ro  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_settle <= '0;
                    end
                end
                StWarm: begin
                    if (r_settle == SettleLast) begin
                        r_win_cnt <= '0;
`ifdef RO_FREQ_COUNTER_CONT_EN
                        r_acc     <= '0;
                        r_acc_ovf <= 1'b0;
`endif
                        if (r_win != '0) begin
                            r_state <= StMeasure;
                        end else begin
                            r_state <= StHold;
                            r_en_ro <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                StMeasure: begin
                    r_done <= 1'b0;
                    if (w_win_last) begin
                        // The final window cycle's edge is folded into the published result.
                        r_count <= w_acc_next;
                        r_ovf   <= w_acc_ovf_next;
                        r_done  <= 1'b1;
`ifdef RO_FREQ_COUNTER_CONT_EN
                        r_win_cnt <= '0;
                        r_acc     <= '0;
                        r_acc_ovf <= 1'b0;
                        if (!START) begin
                            r_state <= StHold;
                            r_en_ro <= 1'b0;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= StHold;
                        r_en_ro <= 1'b0;
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
`ifdef RO_FREQ_COUNTER_CONT_EN
                        r_acc     <= w_acc_next;
                        r_acc_ovf <= w_acc_ovf_next;
`else
                        r_count   <= w_acc_next;
                        r_ovf     <= w_acc_ovf_next;
`endif
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign EN_RO = r_en_ro;
    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign COUNT = r_count;
    assign OVF   = r_ovf;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter: two instances (16-bit and 4-bit count) share stimulus;
// a timeline model of the measurement is compared every cycle, plus literal spot checks.
module tb_ro_freq_counter;

    localparam int SETTLE = 4;

    logic        CLK;
    logic        RN;
    logic        RO_IN;
    logic        START;
    logic [15:0] WIN;

    logic        en16, busy16, done16, ovf16;
    logic [15:0] cnt16;
    logic        en4, busy4, done4, ovf4;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_errors = 0;

    int ro_half;
    int ro_rises;

    // Model state: measurement described as a timeline of edge numbers.
    int cyc;
    bit m_active;
    bit m_done;
    bit m_res_valid;
    int m_w;
    int m_win_start;
    int m_end;
    int m_rises_start;
    int m_ideal;
    int m_tol;

    ro_freq_counter #(
        .CNT_W (16),
        .WIN_W (16),
        .SETTLE (SETTLE),
        .SYNC_STAGES (2)
    ) u_dut16 (
        .CLK   (CLK),
        .RN    (RN),
        .RO_IN (RO_IN),
        .START (START),
        .WIN   (WIN),
        .EN_RO (en16),
        .BUSY  (busy16),
        .DONE  (done16),
        .COUNT (cnt16),
        .OVF   (ovf16)
    );

    ro_freq_counter #(
        .CNT_W (4),
        .WIN_W (16),
        .SETTLE (SETTLE),
        .SYNC_STAGES (2)
    ) u_dut4 (
        .CLK   (CLK),
        .RN    (RN),
        .RO_IN (RO_IN),
        .START (START),
        .WIN   (WIN),
        .EN_RO (en4),
        .BUSY  (busy4),
        .DONE  (done4),
        .COUNT (cnt4),
        .OVF   (ovf4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RO toggles stay at phase 2 (mod 10) so they never coincide with a CLK edge.
    initial begin
        RO_IN    = 1'b0;
        ro_rises = 0;
        #2;
        forever begin
            #(ro_half);
            RO_IN = ~RO_IN;
            if (RO_IN) ro_rises++;
        end
    end

    task automatic check(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d, t=%0t)",
                     nm, act, lo, hi, cyc, $time);
        end
    endtask

    task automatic chk_res(input string nm, input int cnt, input int ovf, input int maxv);
        int lo;
        int hi;
        lo = m_ideal - m_tol;
        if (lo < 0) lo = 0;
        hi = m_ideal + m_tol;
        check({"count", nm}, cnt, (lo > maxv) ? maxv : lo, (hi > maxv) ? maxv : hi);
        if (lo > maxv) check({"ovf", nm}, ovf, 1, 1);
        else if (hi <= maxv) check({"ovf", nm}, ovf, 0, 0);
    endtask

    task automatic m_reset();
        m_active    = 1'b0;
        m_done      = 1'b0;
        m_res_valid = 1'b1;
        m_ideal     = 0;
        m_tol       = 0;
        m_w         = 0;
        m_win_start = 0;
        m_end       = 0;
    endtask

    // Model: accept at edge A, count RO rises between edges A+SETTLE and A+SETTLE+W.
    initial begin
        cyc = 0;
        m_reset();
        forever begin
            @(posedge CLK or negedge RN);
            if (!RN) begin
                m_reset();
            end else begin
                cyc++;
                if (m_active) begin
                    if (cyc == m_win_start) m_rises_start = ro_rises;
                    if (cyc == m_end) begin
                        m_ideal     = ro_rises - m_rises_start;
                        m_tol       = (m_w == 0) ? 0 : 1;
                        m_res_valid = 1'b1;
                        m_done      = 1'b1;
`ifdef RO_FREQ_COUNTER_CONT_EN
                        if (START && m_w != 0) begin
                            m_win_start   = cyc;
                            m_end         = cyc + m_w;
                            m_rises_start = ro_rises;
                        end else begin
                            m_active = 1'b0;
                        end
`else
                        m_active = 1'b0;
`endif
                    end else begin
                        m_done = 1'b0;
                    end
                end else if (START) begin
                    m_active    = 1'b1;
                    m_done      = 1'b0;
                    m_w         = int'(WIN);
                    m_win_start = cyc + SETTLE;
                    m_end       = cyc + SETTLE + m_w;
`ifdef RO_FREQ_COUNTER_CONT_EN
                    m_ideal     = 0;
                    m_tol       = 0;
                    m_res_valid = 1'b1;
`else
                    m_res_valid = 1'b0;
`endif
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge CLK);
            check("en_ro16", int'(en16), int'(m_active), int'(m_active));
            check("busy16", int'(busy16), int'(m_active), int'(m_active));
            check("done16", int'(done16), int'(m_done), int'(m_done));
            check("en_ro4", int'(en4), int'(m_active), int'(m_active));
            check("busy4", int'(busy4), int'(m_active), int'(m_active));
            check("done4", int'(done4), int'(m_done), int'(m_done));
            if (m_res_valid) begin
                chk_res("16", int'(cnt16), int'(ovf16), 65535);
                chk_res("4", int'(cnt4), int'(ovf4), 15);
            end
        end
    end

    task automatic skip(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Called 1 time unit after an edge ("cycle 0"); START is seen at the next edge.
    task automatic start_meas(input int w);
        START = 1'b1;
        WIN   = 16'(w);
        skip(1);
        START = 1'b0;
    endtask

    initial begin
        RN      = 1'b1;
        START   = 1'b0;
        WIN     = '0;
        ro_half = 50;
        #1 RN = 1'b0;
        repeat (3) @(posedge CLK);
        #3 RN = 1'b1;
        skip(1);

        check("rst_en_ro", int'(en16), 0, 0);
        check("rst_busy", int'(busy16), 0, 0);
        check("rst_done", int'(done16), 0, 0);
        check("rst_count", int'(cnt16), 0, 0);
        check("rst_ovf", int'(ovf16), 0, 0);

        // 10 MHz RO, WIN=100
        start_meas(100);
        check("t1_busy_c1", int'(busy16), 1, 1);
        check("t1_en_c1", int'(en16), 1, 1);
        skip(103);
        check("t1_done_c104", int'(done16), 0, 0);
        skip(1);
        check("t1_done_c105", int'(done16), 1, 1);
        check("t1_count", int'(cnt16), 9, 11);
        check("t1_ovf", int'(ovf16), 0, 0);
        check("t1_en_hold", int'(en16), 0, 0);
        check("t1_busy_hold", int'(busy16), 0, 0);

        // WIN=0
        start_meas(0);
        check("t2_done_clr", int'(done16), 0, 0);
        skip(3);
        check("t2_done_c4", int'(done16), 0, 0);
        skip(1);
        check("t2_done_c5", int'(done16), 1, 1);
        check("t2_count", int'(cnt16), 0, 0);
        check("t2_ovf", int'(ovf16), 0, 0);

        // 25 MHz RO saturates the 4-bit instance
        ro_half = 20;
        skip(10);
        start_meas(100);
        skip(104);
        check("t3_done", int'(done4), 1, 1);
        check("t3_count4", int'(cnt4), 15, 15);
        check("t3_ovf4", int'(ovf4), 1, 1);
        check("t3_count16", int'(cnt16), 24, 26);
        check("t3_ovf16", int'(ovf16), 0, 0);
        ro_half = 100;
        skip(20);
        start_meas(20);
        skip(24);
        check("t3b_done4", int'(done4), 1, 1);
        check("t3b_ovf4", int'(ovf4), 0, 0);
        check("t3b_count4", int'(cnt4), 1, 3);

        // Reset in the middle of MEASURE
        ro_half = 50;
        skip(10);
        start_meas(100);
        skip(53);
        #2 RN = 1'b0;
        #1;
        check("t4_rst_en_ro", int'(en16), 0, 0);
        check("t4_rst_busy", int'(busy16), 0, 0);
        check("t4_rst_done", int'(done16), 0, 0);
        check("t4_rst_count", int'(cnt16), 0, 0);
        check("t4_rst_ovf", int'(ovf16), 0, 0);
        check("t4_rst_en_ro4", int'(en4), 0, 0);
        repeat (2) @(posedge CLK);
        #3 RN = 1'b1;
        skip(1);
        start_meas(30);
        skip(34);
        check("t4_done", int'(done16), 1, 1);
        check("t4_count", int'(cnt16), 2, 4);

        // START and WIN disturbed mid-MEASURE
        start_meas(60);
        skip(29);
        START = 1'b1;
        WIN   = 16'd7;
        skip(3);
        START = 1'b0;
        WIN   = '0;
        skip(31);
        check("t5_done_c64", int'(done16), 0, 0);
        check("t5_busy_c64", int'(busy16), 1, 1);
        skip(1);
        check("t5_done_c65", int'(done16), 1, 1);
        check("t5_count", int'(cnt16), 5, 7);

`ifdef RO_FREQ_COUNTER_CONT_EN
        // Continuous windows with START held
        START = 1'b1;
        WIN   = 16'd50;
        skip(54);
        check("t6_done_c54", int'(done16), 0, 0);
        skip(1);
        check("t6_done_c55", int'(done16), 1, 1);
        check("t6_count1", int'(cnt16), 4, 6);
        check("t6_busy_c55", int'(busy16), 1, 1);
        skip(1);
        check("t6_done_c56", int'(done16), 0, 0);
        check("t6_en_c56", int'(en16), 1, 1);
        skip(49);
        check("t6_done_c105", int'(done16), 1, 1);
        check("t6_count2", int'(cnt16), 4, 6);
        skip(1);
        check("t6_done_c106", int'(done16), 0, 0);
        skip(24);
        START = 1'b0;
        skip(25);
        check("t6_done_c155", int'(done16), 1, 1);
        check("t6_busy_c155", int'(busy16), 0, 0);
        skip(5);
        check("t6_done_held", int'(done16), 1, 1);
        check("t6_en_hold", int'(en16), 0, 0);
`endif

        skip(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
